// File: rtl/sha256_ureg_sequencer.sv
// sha256_ureg_sequencer: streams padded blocks into the SHA-256 ureg slave, polls progress/done and returns the digest
module sha256_ureg_sequencer #(
  parameter int POLL_MAX = 1023
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         blk_val,
  output logic         blk_rdy,
  input  logic [511:0] blk_data,
  input  logic         blk_last,
  output logic         dig_val,
  input  logic         dig_rdy,
  output logic [255:0] dig_data,
  input  logic         ureg_req_rdy,
  output logic         ureg_req_val,
  output logic [11:0]  ureg_req_addr,
  output logic [7:0]   ureg_req_strb,
  output logic [63:0]  ureg_req_data,
  output logic         ureg_resp_rdy,
  input  logic         ureg_resp_val,
  input  logic [63:0]  ureg_resp_data,
  input  logic         ureg_resp_ecc,
  output logic         busy,
  output logic         err,
  output logic [1:0]   err_code
);
  typedef enum logic [2:0] {IDLE, WRITE, PROGRESS, DONE, DIGEST, OUT, ERR} state_t;
  state_t state_q, state_d;
  logic [2:0] word_q, word_d;
  logic [15:0] poll_q, poll_d;
  logic [511:0] buf_q, buf_d;
  logic last_q, last_d;
  logic [255:0] dig_q, dig_d;
  logic req_val_q, req_val_d;
  logic resp_rdy_q, resp_rdy_d;
  logic err_q, err_d;
  logic [1:0] code_q, code_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0] strb_q, strb_d;
  logic [63:0] data_q, data_d;
  logic resp_fire, zero, poll_end, iss;
  assign resp_fire = resp_rdy_q & ureg_resp_val;
  assign zero = ureg_resp_data == '0;
  assign poll_end = poll_q == 16'(POLL_MAX - 1);
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    poll_d = poll_q;
    buf_d = buf_q;
    last_d = last_q;
    dig_d = dig_q;
    req_val_d = req_val_q;
    resp_rdy_d = resp_rdy_q;
    err_d = err_q;
    code_d = code_q;
    addr_d = addr_q;
    strb_d = strb_q;
    data_d = data_q;
    iss = 1'b0;
    if (req_val_q && ureg_req_rdy) begin
      req_val_d = 1'b0;
      resp_rdy_d = 1'b1;
    end
    if (resp_fire) resp_rdy_d = 1'b0;
    if (resp_fire && ureg_resp_ecc) begin
      state_d = ERR;
      err_d = 1'b1;
      code_d = 2'd1;
    end else begin
      case (state_q)
        IDLE: if (blk_val) begin
          buf_d = blk_data;
          last_d = blk_last;
          word_d = 3'd0;
          state_d = WRITE;
          iss = 1'b1;
        end
        WRITE: if (resp_fire) begin
          iss = 1'b1;
          state_d = word_q == 3'd7 ? PROGRESS : WRITE;
          word_d = word_q == 3'd7 ? 3'd0 : word_q + 3'd1;
          poll_d = '0;
        end
        PROGRESS: if (resp_fire) begin
          if (zero && poll_end) begin
            state_d = ERR;
            err_d = 1'b1;
            code_d = 2'd2;
          end else begin
            iss = zero || last_q;
            state_d = zero ? PROGRESS : last_q ? DONE : IDLE;
            poll_d = zero ? poll_q + 16'd1 : '0;
          end
        end
        DONE: if (resp_fire) begin
          if (zero && poll_end) begin
            state_d = ERR;
            err_d = 1'b1;
            code_d = 2'd3;
          end else begin
            iss = 1'b1;
            state_d = zero ? DONE : DIGEST;
            poll_d = zero ? poll_q + 16'd1 : '0;
            word_d = 3'd0;
          end
        end
        DIGEST: if (resp_fire) begin
          dig_d[{word_q[1:0], 6'd0} +: 64] = ureg_resp_data;
          iss = word_q != 3'd3;
          state_d = word_q == 3'd3 ? OUT : DIGEST;
          word_d = word_q == 3'd3 ? 3'd0 : word_q + 3'd1;
        end
        OUT: if (dig_rdy) state_d = IDLE;
        default: ;
      endcase
    end
    // the request to launch is derived from where the FSM is heading
    if (iss) begin
      req_val_d = 1'b1;
      addr_d = state_d == WRITE ? {6'd0, word_d, 3'd0} :
               state_d == PROGRESS ? 12'h068 :
               state_d == DONE ? 12'h070 : {7'd2, word_d[1:0], 3'd0};
      strb_d = state_d == WRITE ? 8'hff : 8'h00;
      data_d = state_d == WRITE ? buf_d[{word_d, 6'd0} +: 64] : '0;
    end
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      word_q <= '0;
      poll_q <= '0;
      buf_q <= '0;
      last_q <= 1'b0;
      dig_q <= '0;
      req_val_q <= 1'b0;
      resp_rdy_q <= 1'b0;
      err_q <= 1'b0;
      code_q <= '0;
      addr_q <= '0;
      strb_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      poll_q <= poll_d;
      buf_q <= buf_d;
      last_q <= last_d;
      dig_q <= dig_d;
      req_val_q <= req_val_d;
      resp_rdy_q <= resp_rdy_d;
      err_q <= err_d;
      code_q <= code_d;
      addr_q <= addr_d;
      strb_q <= strb_d;
      data_q <= data_d;
    end
  end
  assign blk_rdy = state_q == IDLE;
  assign dig_val = state_q == OUT;
  assign busy = state_q != IDLE;
  assign dig_data = dig_q;
  assign ureg_req_val = req_val_q;
  assign ureg_req_addr = addr_q;
  assign ureg_req_strb = strb_q;
  assign ureg_req_data = data_q;
  assign ureg_resp_rdy = resp_rdy_q;
  assign err = err_q;
  assign err_code = code_q;
endmodule

// File: tb/tb_sha256_ureg_sequencer.sv
// tb_sha256_ureg_sequencer: ureg slave model with request/digest scoreboards around the sequencer
module tb_sha256_ureg_sequencer;
  localparam logic [255:0] DIG_ABC = 256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD;
  localparam logic [255:0] DIG_TWO = 256'h248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1;
  localparam logic [511:0] BLK_ABC = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] BLK_T0 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 64'h8000000000000000};
  localparam logic [511:0] BLK_T1 = {448'h0, 64'h1C0};

  logic sys_clk = 0, sys_rst = 1;
  logic blk_val = 0, blk_rdy, blk_last = 0;
  logic [511:0] blk_data = '0;
  logic dig_val, dig_rdy = 1;
  logic [255:0] dig_data;
  logic ureg_req_rdy, ureg_req_val, ureg_resp_rdy, ureg_resp_val, ureg_resp_ecc;
  logic [11:0] ureg_req_addr;
  logic [7:0] ureg_req_strb;
  logic [63:0] ureg_req_data, ureg_resp_data;
  logic busy, err;
  logic [1:0] err_code;

  sha256_ureg_sequencer #(.POLL_MAX(3)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .blk_val(blk_val), .blk_rdy(blk_rdy), .blk_data(blk_data), .blk_last(blk_last),
    .dig_val(dig_val), .dig_rdy(dig_rdy), .dig_data(dig_data),
    .ureg_req_rdy(ureg_req_rdy), .ureg_req_val(ureg_req_val), .ureg_req_addr(ureg_req_addr),
    .ureg_req_strb(ureg_req_strb), .ureg_req_data(ureg_req_data),
    .ureg_resp_rdy(ureg_resp_rdy), .ureg_resp_val(ureg_resp_val),
    .ureg_resp_data(ureg_resp_data), .ureg_resp_ecc(ureg_resp_ecc),
    .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {logic [11:0] a; logic [7:0] s; logic [63:0] d;} req_t;
  req_t exp_q[$];
  logic [255:0] dig_q[$];
  int checks = 0, errors = 0;
  bit rdy_rand = 0, dly_rand = 0;
  int ecc_at = 0, prog_zeros = 0, done_zeros = 0, wr_cnt = 0;
  logic [255:0] slv_dig = '0;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // slave: decides handshakes at negedge, updates its drives just after posedge
  initial begin
    bit acc, rsp, pend, stall_prev, re;
    int dly, pz, dz, idx;
    logic [63:0] rd;
    req_t cap, e;
    ureg_req_rdy = 0; ureg_resp_val = 0; ureg_resp_data = 0; ureg_resp_ecc = 0;
    pend = 0; stall_prev = 0; dly = 0; pz = 0; dz = 0; rd = 0; re = 0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        pend = 0; pz = 0; dz = 0; wr_cnt = 0; stall_prev = 0;
        ureg_resp_val = 0; ureg_resp_ecc = 0; ureg_req_rdy = 0;
        continue;
      end
      acc = ureg_req_val && ureg_req_rdy;
      rsp = ureg_resp_rdy && ureg_resp_val;
      if (stall_prev)
        chk("req_hold", {ureg_req_val, ureg_req_addr, ureg_req_strb, ureg_req_data}, {1'b1, cap});
      stall_prev = ureg_req_val && !ureg_req_rdy;
      cap = {ureg_req_addr, ureg_req_strb, ureg_req_data};
      if (acc) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: addr %h strb %h expected none", cap.a, cap.s);
        end else begin
          e = exp_q.pop_front();
          chk("req_addr", cap.a, e.a);
          chk("req_strb", cap.s, e.s);
          if (e.s != 8'h00) chk("req_data", cap.d, e.d);
        end
      end
      @(posedge sys_clk); #1;
      if (sys_rst) continue;
      if (rsp) begin
        ureg_resp_val = 0; ureg_resp_ecc = 0; ureg_resp_data = 0; pend = 0;
      end
      if (acc) begin
        pend = 1; rd = 0; re = 0;
        dly = dly_rand ? int'($urandom_range(0, 3)) : 0;
        if (cap.s != 8'h00) begin
          wr_cnt++;
          re = wr_cnt == ecc_at;
        end else if (cap.a == 12'h068) begin
          rd = pz < prog_zeros ? 64'd0 : 64'd1;
          pz = pz < prog_zeros ? pz + 1 : 0;
        end else if (cap.a == 12'h070) begin
          rd = dz < done_zeros ? 64'd0 : 64'h5;
          dz = dz < done_zeros ? dz + 1 : 0;
        end else begin
          idx = (int'(cap.a) - 'h40) >> 3;
          rd = slv_dig[idx*64 +: 64];
        end
      end
      if (pend && !ureg_resp_val) begin
        if (dly == 0) begin
          ureg_resp_val = 1; ureg_resp_data = rd; ureg_resp_ecc = re;
        end else dly--;
      end
      ureg_req_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // digest monitor
  initial begin
    bit prev_v, took;
    logic [255:0] prev_d, e;
    prev_v = 0; took = 0; prev_d = '0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        prev_v = 0; took = 0;
        continue;
      end
      if (prev_v) chk("dig_hold", dig_data, prev_d);
      if (took) chk("dig_val_fall", {dig_val, blk_rdy}, 2'b01);
      took = dig_val && dig_rdy;
      if (took) begin
        if (dig_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_dig: got %h expected none", dig_data);
        end else begin
          e = dig_q.pop_front();
          chk("digest", dig_data, e);
        end
      end
      prev_v = dig_val && !dig_rdy;
      prev_d = dig_data;
    end
  end

  task automatic push_rd(logic [11:0] a, int n);
    repeat (n) exp_q.push_back({a, 8'h00, 64'h0});
  endtask

  task automatic push_wr(logic [511:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back({12'(i * 8), 8'hff, b[i*64 +: 64]});
  endtask

  task automatic push_block(logic [511:0] b, logic last, logic [255:0] d, int pz, int dz);
    push_wr(b);
    push_rd(12'h068, pz + 1);
    if (last) begin
      push_rd(12'h070, dz + 1);
      for (int i = 0; i < 4; i++) push_rd(12'(12'h040 + i * 8), 1);
      dig_q.push_back(d);
    end
  endtask

  task automatic send(logic [511:0] b, logic last);
    int n = 0;
    while (!blk_rdy && n < 3000) begin
      @(posedge sys_clk); #1; n++;
    end
    chk("blk_rdy_wait", blk_rdy, 1'b1);
    blk_data = b; blk_last = last; blk_val = 1;
    @(posedge sys_clk); #1;
    blk_val = 0;
    chk("first_req_lat", {ureg_req_val, busy, blk_rdy}, 3'b110);
  endtask

  task automatic drain(string name);
    int n = 0;
    while ((busy || exp_q.size() != 0 || dig_q.size() != 0) && n < 3000) begin
      @(posedge sys_clk); #1; n++;
    end
    chk(name, n < 3000, 1'b1);
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1; blk_val = 0;
    wait_cyc(2);
    exp_q.delete(); dig_q.delete();
    sys_rst = 0;
  endtask

  task automatic chk_reset_vals(string name);
    chk(name, {ureg_req_val, ureg_req_addr, ureg_req_strb, ureg_req_data, ureg_resp_rdy,
               dig_val, err, err_code, busy, blk_rdy, dig_data},
        {1'b0, 12'h0, 8'h0, 64'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 256'h0});
  endtask

  initial begin
    int n;
    wait_cyc(2);
    chk_reset_vals("reset_state");
    sys_rst = 0;
    wait_cyc(2);
    chk_reset_vals("idle_after_reset");

    slv_dig = DIG_ABC;
    push_block(BLK_ABC, 1, DIG_ABC, 0, 0);
    send(BLK_ABC, 1);
    drain("abc_done");
    chk("abc_no_err", err, 1'b0);

    slv_dig = DIG_TWO;
    push_block(BLK_T0, 0, '0, 0, 0);
    send(BLK_T0, 0);
    push_block(BLK_T1, 1, DIG_TWO, 0, 0);
    send(BLK_T1, 1);
    drain("two_done");

    slv_dig = DIG_ABC;
    rdy_rand = 1; dly_rand = 1; prog_zeros = 2; done_zeros = 2; dig_rdy = 0;
    push_block(BLK_ABC, 1, DIG_ABC, 2, 2);
    send(BLK_ABC, 1);
    n = 0;
    while (!dig_val && n < 3000) begin
      @(posedge sys_clk); #1; n++;
    end
    chk("bp_dig_wait", dig_val, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {dig_val, blk_rdy, busy}, 3'b101);
      wait_cyc(1);
    end
    dig_rdy = 1;
    drain("bp_done");
    rdy_rand = 0; dly_rand = 0; prog_zeros = 0; done_zeros = 0;

    do_reset();
    ecc_at = 3;
    push_wr(BLK_ABC);
    exp_q = exp_q[0:2];
    send(BLK_ABC, 1);
    wait_cyc(30);
    chk("ecc_err", {err, err_code, blk_rdy, busy, ureg_req_val, ureg_resp_rdy, dig_val},
        {1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("ecc_reqs_left", exp_q.size(), 0);
    do_reset();
    ecc_at = 0;

    prog_zeros = 3;
    push_wr(BLK_ABC);
    push_rd(12'h068, 3);
    send(BLK_ABC, 1);
    wait_cyc(40);
    chk("prog_timeout", {err, err_code, blk_rdy, busy}, {1'b1, 2'd2, 1'b0, 1'b1});
    chk("prog_polls_left", exp_q.size(), 0);
    do_reset();
    prog_zeros = 0; done_zeros = 3;
    push_wr(BLK_ABC);
    push_rd(12'h068, 1);
    push_rd(12'h070, 3);
    send(BLK_ABC, 1);
    wait_cyc(40);
    chk("done_timeout", {err, err_code, blk_rdy, busy}, {1'b1, 2'd3, 1'b0, 1'b1});
    chk("done_polls_left", exp_q.size(), 0);
    do_reset();
    done_zeros = 0;

    push_block(BLK_ABC, 1, DIG_ABC, 0, 0);
    send(BLK_ABC, 1);
    n = 0;
    while (!(ureg_req_val && ureg_req_addr == 12'h020) && n < 200) begin
      @(posedge sys_clk); #1; n++;
    end
    chk("reach_word4", {ureg_req_val, ureg_req_addr}, {1'b1, 12'h020});
    #2;
    sys_rst = 1;
    #1;
    chk_reset_vals("async_reset");
    do_reset();
    push_block(BLK_ABC, 1, DIG_ABC, 0, 0);
    send(BLK_ABC, 1);
    drain("rerun_done");
    chk("rerun_no_err", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sha256_ureg_sequencer.md
# sha256_ureg_sequencer

Synthesizable master that drives the SHA-256 accelerator's 64-bit ureg register port on behalf of an upstream message-block source. Accepts pre-padded 512-bit blocks on a valid/ready stream, writes them, polls progress and done, reads the 256-bit digest and presents it on a valid/ready output. Sits between application logic and the accelerator's ureg slave, replacing software/testbench register sequencing.

## Interface
- `POLL_MAX`, 1023: consecutive zero poll responses tolerated per wait before timeout error (1..65535).
- `sys_clk`  in  1  clock; also forwarded to the accelerator.
- `sys_rst`  in  1  reset, asynchronous, active-high.
- `blk_val`  in  1  upstream block valid.
- `blk_rdy`  out  1  sequencer can accept a block.
- `blk_data`  in  512  padded block; 64-bit word i = `blk_data[i*64 +: 64]`.
- `blk_last`  in  1  block is final block of the message.
- `dig_val`  out  1  digest valid.
- `dig_rdy`  in  1  downstream accepts digest.
- `dig_data`  out  256  digest; word i = `dig_data[i*64 +: 64]`.
- `ureg_req_rdy`  in  1  slave accepts request.
- `ureg_req_val`  out  1  request valid.
- `ureg_req_addr`  out  12  byte address.
- `ureg_req_strb`  out  8  write strobe; 8'h00 = read.
- `ureg_req_data`  out  64  write data.
- `ureg_resp_rdy`  out  1  ready for response.
- `ureg_resp_val`  in  1  response valid.
- `ureg_resp_data`  in  64  response data.
- `ureg_resp_ecc`  in  1  response error flag.
- `busy`  out  1  state != IDLE.
- `err`  out  1  sticky error, cleared only by reset.
- `err_code`  out  2  0 none, 1 ECC, 2 progress timeout, 3 done timeout.

## Operation
- Register map: block words 0x00 + 8*i (i=0..7, write, strb 8'hff); digest words 0x40 + 8*i (i=0..3, read); progress 0x68 (read, nonzero = block absorbed); done 0x70 (read, nonzero = digest ready).
- One request outstanding at a time. Request phase: `ureg_req_*` registered, held stable until `ureg_req_val & ureg_req_rdy`; next cycle `ureg_req_val`=0, `ureg_resp_rdy`=1 until `ureg_resp_val`. Response consumed on `ureg_resp_val & ureg_resp_rdy`.
- States:
  - IDLE: `blk_rdy`=1. On `blk_val`: capture `blk_data`, `blk_last` into buffer, word_ctr=0 -> WRITE.
  - WRITE: write word word_ctr; on response, word_ctr==7 -> PROGRESS (word_ctr=0), else word_ctr+1.
  - PROGRESS: read 0x68; nonzero -> DONE if last else IDLE; zero -> poll_ctr+1, reissue.
  - DONE: read 0x70; nonzero -> DIGEST; zero -> poll_ctr+1, reissue.
  - DIGEST: read word word_ctr into `dig_data[word_ctr*64 +: 64]`; word_ctr==3 -> OUT.
  - OUT: `dig_val`=1 until `dig_rdy`, then IDLE.
  - ERR: terminal; all handshake outputs 0, `busy`=1.
- poll_ctr (16 bit) cleared on entry to PROGRESS and DONE; zero response when poll_ctr == POLL_MAX-1 -> ERR with code 2/3.
- Any consumed response with `ureg_resp_ecc`=1 -> ERR, code 1, regardless of state; data discarded.
- Write responses: data ignored, only ecc checked.

## Timing
- Reset: state IDLE, all counters 0, buffer 0, `dig_data`=0, `ureg_req_val`=0, `ureg_req_addr`=0, `ureg_req_strb`=0, `ureg_req_data`=0, `ureg_resp_rdy`=0, `dig_val`=0, `err`=0, `err_code`=0, `busy`=0, `blk_rdy`=1 (combinational from state).
- Block capture -> first `ureg_req_val`: 1 cycle.
- Each transaction with zero-wait slave (rdy=1, resp next cycle): 2 cycles; next request issued the cycle after response consumed. Minimum block absorb (immediate progress): 18 cycles; final block adds done + 4 digest reads.
- `dig_data` stable while `dig_val`=1; `dig_val` falls cycle after `dig_rdy`; `blk_rdy` rises same cycle state returns to IDLE.
- `ureg_resp_val` while no request outstanding: ignored, never consumed.
- Reset mid-transaction: immediate return to reset values; outstanding accelerator transaction abandoned (accelerator reset via same line).

## Test plan
- "abc": one block 512'h6162638000...0018, last=1 -> `dig_data`=256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD, 8 writes at 0x00..0x38 then reads 0x68, 0x70, 0x40..0x58.
- Two-block "abcdbcde..." (second block ...01C0), first last=0 -> single `dig_val`, digest 248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1; no 0x70 read after block 0.
- Backpressure: random `ureg_req_rdy`, delayed `ureg_resp_val`, `dig_rdy` held low 10 cycles -> request fields stable while unaccepted, same digest, `blk_rdy`=0 until digest taken.
- ECC: `ureg_resp_ecc`=1 on third write response -> `err`=1, `err_code`=1, no further requests, `blk_rdy`=0 until reset.
- Timeout, POLL_MAX=3: progress reads return 0 three times -> `err_code`=2 after exactly 3 polls; same for done -> `err_code`=3.
- Async reset asserted mid-WRITE (word 4) -> outputs at reset values without clock edge; rerun "abc" after release -> correct digest.
